usart_rx_fifo: RTL and testbench
================================

Name: usart_rx_fifo

Overview:
- Parametrised UART receiver for the fidget usart library, the successor to the fixed 8N1 echo path.
- Adds configurable data width, parity, 1/2 stop bits, start-bit glitch rejection, per-frame error flags, a show-ahead RX FIFO and RTS flow control.
- Sits between the board rx_pin/rts_pin and any comm_clock-domain consumer (echo, bus bridge, CPU peripheral).

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- FIFO_DEPTH, 16, RX FIFO entries; power of two, >= 2.
- RTS_THRESHOLD, 12, fill level at or above which rts_pin deasserts (high); 1..FIFO_DEPTH.
- CPB_WIDTH, 12, width of clocks_per_bit.

Ports:
- comm_clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- clocks_per_bit  in  CPB_WIDTH  comm_clock cycles per bit; latched at start-bit detect; legal >= 4.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none).
- two_stop_bits  in  1  1 = check two stop bits.
- rx_pin  in  1  async serial input, idle high.
- rts_pin  out  1  0 = peer may send, 1 = stop.
- rx_data  out  DATA_BITS  FIFO head data.
- rx_parity_error  out  1  FIFO head parity flag.
- rx_frame_error  out  1  FIFO head framing flag.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pop; pop occurs when rx_valid & rx_ready.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- clear_errors  in  1  clears overrun (priority over a same-cycle set).
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: rx_data, both flags, rx_valid, overrun and fifo_count are 0; rts_pin is 1; the synchroniser flops are 1; FSM is IDLE.
- rts_pin goes 0 on the first clock after reset release.
- rx_pin passes through a 2-flop synchroniser; the FSM uses only the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, STORE, WAIT_IDLE. A bit counter reloads to clocks_per_bit-1 and counts down.
- IDLE: rxs==0 -> START, counter = clocks_per_bit/2 - 1 (floor), latch clocks_per_bit.
- START: at counter==0, rxs==1 is a glitch -> IDLE with nothing stored; rxs==0 -> DATA, reload counter.
- DATA: sample at each counter==0 and shift in LSB first. After DATA_BITS samples go to PARITY (mode 1/2) else STOP.
- PARITY: sample once. Error if even mode and XOR(data,bit)==1, or odd mode and XOR(data,bit)==0.
- STOP: sample 1 or 2 bits. Any stop sample 0 sets frame_error. After the last stop sample go to STORE.
- STORE, one cycle:
  - FIFO not full, or full with a same-cycle pop: push {data, parity_err, frame_err}.
  - FIFO full with no pop: drop the frame and set overrun.
  - Next state: frame_err -> WAIT_IDLE, else IDLE.
- WAIT_IDLE: stays until rxs==1, then IDLE. A break (line held low) yields exactly one stored frame with frame_error=1, data all-zero.
- Latency: rx_valid rises 2 cycles after the final stop-bit sample (STORE, then FIFO register) when the FIFO was empty.
- FIFO: show-ahead. Outputs reflect the head whenever rx_valid=1 and are 0 when empty.
  - Pop when empty is ignored.
  - Push+pop same cycle: fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH with an extra MSB for full/empty.
- rts_pin is registered: 1 when fifo_count >= RTS_THRESHOLD, else 0. It updates the cycle after fifo_count changes.
- clocks_per_bit, parity_mode and two_stop_bits changes take effect only at the next start-bit detect.
- Asserting reset_n low mid-frame aborts the frame immediately and empties the FIFO.

Decomposition:
- usart_pkg holds:
  - parity_mode encodings PARITY_NONE/EVEN/ODD.
  - FSM state constants.
  - FIFO entry width constant DATA_BITS+2.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; show-ahead; count output) is natural and reused by a future TX path. The FSM, synchroniser and RTS logic stay in usart_rx_fifo.

Test Plan:
- cpb=32, 8N1, send 0x75 then 0x8A (LSB first, 32-cycle bits): rx_data reads 0x75 then 0x8A, flags 0, rx_valid drops after two pops.
- Even parity, send 0x07 with parity bit 1: parity_error=0. Resend with parity bit 0: parity_error=1, data 0x07.
- Low glitch of 10 cycles on idle line (cpb=32): no push, fifo_count stays 0, FSM back in IDLE.
- Break of 20 bit-times low: exactly one entry, data 0x00, frame_error=1. No further entries until the line returns high and a new frame is sent.
- rx_ready=0, DEPTH=16, THRESHOLD=12, send 17 frames:
  - rts_pin rises one cycle after count hits 12.
  - Count saturates at 16.
  - overrun=1 after the 17th frame; the first 16 frames are intact.
  - clear_errors -> overrun=0.
- Reset_n pulsed low mid-DATA bit 4 with 3 entries queued: fifo_count=0 and rts_pin=1 immediately. The next full frame is received correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared encodings for the usart library: parity modes, RX FSM states and FIFO entry sizing.
package usart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_STORE,
    RX_WAIT_IDLE
  } rx_state_e;

  // Each FIFO entry carries the data word plus parity and framing flags.
  localparam int unsigned FLAG_BITS = 2;

  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + FLAG_BITS;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             valid,
  output logic             full_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic             do_push_c, do_pop_c;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop_c  = pop && valid;
    do_push_c = push && (!full_c || do_pop_c);
    wr_ptr_n  = wr_ptr_q + PTR_W'(do_push_c);
    rd_ptr_n  = rd_ptr_q + PTR_W'(do_pop_c);
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      valid    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count    <= CNT_W'(wr_ptr_n - rd_ptr_n);
      valid    <= (wr_ptr_n != rd_ptr_n);
    end
  end

  assign rdata_c = valid ? mem[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: rtl/usart_rx_fifo.sv
// Parametrised UART receiver: synchroniser, framing FSM with parity/stop checks,
// show-ahead RX FIFO with per-frame flags, sticky overrun and RTS flow control.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter  int unsigned DATA_BITS     = 8,
  parameter  int unsigned FIFO_DEPTH    = 16,
  parameter  int unsigned RTS_THRESHOLD = 12,
  parameter  int unsigned CPB_WIDTH     = 12,
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 comm_clock,
  input  logic                 reset_n,
  input  logic [CPB_WIDTH-1:0] clocks_per_bit,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop_bits,
  input  logic                 rx_pin,
  output logic                 rts_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_error,
  output logic                 rx_frame_error,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 clear_errors,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int unsigned ENTRY_W = entry_width(DATA_BITS);
  localparam int unsigned BI_W    = $clog2(DATA_BITS + 1);

  logic                 rx_meta, rxs;
  rx_state_e            state_q, state_n;
  logic [CPB_WIDTH-1:0] cnt_q, cnt_n;
  logic [CPB_WIDTH-1:0] cpb_q, cpb_n;
  logic [1:0]           pmode_q, pmode_n;
  logic                 two_stop_q, two_stop_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_n;
  logic                 stop_idx_q, stop_idx_n;
  logic                 par_err_q, par_err_n;
  logic                 frame_err_q, frame_err_n;

  logic                 store_c, ovr_set_c, pop_c;
  logic                 fifo_full_c;
  logic [ENTRY_W-1:0]   head_c;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rxs     <= rx_meta;
    end
  end

  // State and frame datapath registers.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      cpb_q       <= '0;
      pmode_q     <= PARITY_NONE;
      two_stop_q  <= 1'b0;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      cpb_q       <= cpb_n;
      pmode_q     <= pmode_n;
      two_stop_q  <= two_stop_n;
      shreg_q     <= shreg_n;
      bit_idx_q   <= bit_idx_n;
      stop_idx_q  <= stop_idx_n;
      par_err_q   <= par_err_n;
      frame_err_q <= frame_err_n;
    end
  end

  // Next-state and datapath update; every bit is sampled when the counter hits zero.
  always_comb begin
    logic tick;
    logic par_en;
    state_n     = state_q;
    cnt_n       = cnt_q;
    cpb_n       = cpb_q;
    pmode_n     = pmode_q;
    two_stop_n  = two_stop_q;
    shreg_n     = shreg_q;
    bit_idx_n   = bit_idx_q;
    stop_idx_n  = stop_idx_q;
    par_err_n   = par_err_q;
    frame_err_n = frame_err_q;
    tick        = (cnt_q == '0);
    par_en      = (pmode_q == PARITY_EVEN) || (pmode_q == PARITY_ODD);

    case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          state_n     = RX_START;
          cnt_n       = (clocks_per_bit >> 1) - CPB_WIDTH'(1);
          cpb_n       = clocks_per_bit;
          pmode_n     = parity_mode;
          two_stop_n  = two_stop_bits;
          bit_idx_n   = '0;
          stop_idx_n  = 1'b0;
          par_err_n   = 1'b0;
          frame_err_n = 1'b0;
        end
      end
      RX_START: begin
        if (!tick) begin
          cnt_n = cnt_q - CPB_WIDTH'(1);
        end else if (rxs) begin
          state_n = RX_IDLE;
        end else begin
          state_n = RX_DATA;
          cnt_n   = cpb_q - CPB_WIDTH'(1);
        end
      end
      RX_DATA: begin
        if (!tick) begin
          cnt_n = cnt_q - CPB_WIDTH'(1);
        end else begin
          shreg_n   = {rxs, shreg_q[DATA_BITS-1:1]};
          bit_idx_n = bit_idx_q + BI_W'(1);
          cnt_n     = cpb_q - CPB_WIDTH'(1);
          if (bit_idx_q == BI_W'(DATA_BITS - 1)) begin
            state_n = par_en ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (!tick) begin
          cnt_n = cnt_q - CPB_WIDTH'(1);
        end else begin
          // Even mode expects XOR of data and parity bit to be 0, odd mode 1.
          par_err_n = (^shreg_q) ^ rxs ^ (pmode_q == PARITY_ODD);
          cnt_n     = cpb_q - CPB_WIDTH'(1);
          state_n   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!tick) begin
          cnt_n = cnt_q - CPB_WIDTH'(1);
        end else begin
          if (!rxs) begin
            frame_err_n = 1'b1;
          end
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_n = 1'b1;
            cnt_n      = cpb_q - CPB_WIDTH'(1);
          end else begin
            state_n = RX_STORE;
          end
        end
      end
      RX_STORE: begin
        state_n = frame_err_q ? RX_WAIT_IDLE : RX_IDLE;
      end
      RX_WAIT_IDLE: begin
        if (rxs) begin
          state_n = RX_IDLE;
        end
      end
      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

  // FSM outputs: push request and overrun detection.
  always_comb begin
    store_c   = (state_q == RX_STORE);
    pop_c     = rx_valid && rx_ready;
    ovr_set_c = store_c && fifo_full_c && !pop_c;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (comm_clock),
    .rst_n   (reset_n),
    .push    (store_c),
    .wdata   ({shreg_q, par_err_q, frame_err_q}),
    .pop     (rx_ready),
    .rdata_c (head_c),
    .valid   (rx_valid),
    .full_c  (fifo_full_c),
    .count   (fifo_count)
  );

  assign rx_data         = head_c[ENTRY_W-1:2];
  assign rx_parity_error = head_c[1];
  assign rx_frame_error  = head_c[0];

  // Sticky overrun; a clear wins over a same-cycle drop.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (clear_errors) begin
      overrun <= 1'b0;
    end else if (ovr_set_c) begin
      overrun <= 1'b1;
    end
  end

  // RTS held high in reset so the peer stays quiet until we are running.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      rts_pin <= 1'b1;
    end else begin
      rts_pin <= (fifo_count >= CNT_W'(RTS_THRESHOLD));
    end
  end

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Randomised self-checking bench for usart_rx_fifo against a frame-level queue model.
module tb_usart_rx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned THRESHOLD = 12;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         fe;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] clocks_per_bit;
  logic [1:0]  parity_mode;
  logic        two_stop_bits;
  logic        rx_pin;
  logic        rts_pin;
  logic [7:0]  rx_data;
  logic        rx_parity_error;
  logic        rx_frame_error;
  logic        rx_valid;
  logic        rx_ready;
  logic        overrun;
  logic        clear_errors;
  logic [4:0]  fifo_count;

  entry_t model_q[$];
  bit     model_ovr;
  int     n_total;
  int     n_pass;
  int     prev_cnt;

  usart_rx_fifo dut (
    .comm_clock      (clk),
    .reset_n         (reset_n),
    .clocks_per_bit  (clocks_per_bit),
    .parity_mode     (parity_mode),
    .two_stop_bits   (two_stop_bits),
    .rx_pin          (rx_pin),
    .rts_pin         (rts_pin),
    .rx_data         (rx_data),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .overrun         (overrun),
    .clear_errors    (clear_errors),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic v, input int cycles);
    rx_pin = v;
    tick(cycles);
  endtask

  task automatic model_push(input entry_t e);
    if (model_q.size() < DEPTH) model_q.push_back(e);
    else model_ovr = 1'b1;
  endtask

  // Serialise one frame on rx_pin and record what the receiver should store.
  task automatic send_frame(input logic [7:0] d, input int cpb, input logic [1:0] pm,
                            input bit ts, input bit bad_par, input bit bad_stop, input int gap);
    bit     par_en;
    logic   pbit;
    entry_t e;
    par_en         = (pm == 2'd1) || (pm == 2'd2);
    clocks_per_bit = 12'(cpb);
    parity_mode    = pm;
    two_stop_bits  = ts;
    hold(1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(d[i], cpb);
    if (par_en) begin
      pbit = (^d) ^ (pm == 2'd2) ^ bad_par;
      hold(pbit, cpb);
    end
    hold(~bad_stop, cpb);
    if (ts) hold(1'b1, cpb);
    e.data = d;
    e.pe   = par_en && bad_par;
    e.fe   = bad_stop;
    model_push(e);
    hold(1'b1, gap);
  endtask

  task automatic check_level(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
    check({tag, "_ovr"}, 32'(overrun), 32'(model_ovr));
  endtask

  // Compare the head with the model, then pulse rx_ready (also when empty).
  task automatic pop_check(input string tag);
    entry_t e;
    check({tag, "_valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      e = model_q.pop_front();
      check({tag, "_data"}, 32'(rx_data), 32'(e.data));
      check({tag, "_pe"}, 32'(rx_parity_error), 32'(e.pe));
      check({tag, "_fe"}, 32'(rx_frame_error), 32'(e.fe));
    end else begin
      check({tag, "_empty_data"}, 32'(rx_data), 32'h0);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // RTS must follow fifo_count >= THRESHOLD one cycle later, and be high in reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rts_reset", 32'(rts_pin), 32'h1);
      prev_cnt = 0;
    end else begin
      check("rts_track", 32'(rts_pin), 32'(prev_cnt >= THRESHOLD));
      prev_cnt = int'(fifo_count);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_total        = 0;
    n_pass         = 0;
    prev_cnt       = 0;
    model_ovr      = 1'b0;
    reset_n        = 1'b0;
    rx_pin         = 1'b1;
    rx_ready       = 1'b0;
    clear_errors   = 1'b0;
    clocks_per_bit = 12'd32;
    parity_mode    = 2'd0;
    two_stop_bits  = 1'b0;
    tick(3);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_rts", 32'(rts_pin), 32'h1);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_flags", 32'({rx_parity_error, rx_frame_error}), 32'h0);
    release_reset();
    tick(1);
    check("rts_after_rst", 32'(rts_pin), 32'h0);
    tick(4);

    // 8N1 basic frames.
    send_frame(8'h75, 32, 2'd0, 1'b0, 1'b0, 1'b0, 8);
    send_frame(8'h8A, 32, 2'd0, 1'b0, 1'b0, 1'b0, 8);
    check_level("8n1");
    pop_check("8n1_a");
    pop_check("8n1_b");
    check("8n1_drained", 32'(rx_valid), 32'h0);

    // Even parity, good then bad parity bit.
    send_frame(8'h07, 32, 2'd1, 1'b0, 1'b0, 1'b0, 8);
    send_frame(8'h07, 32, 2'd1, 1'b0, 1'b1, 1'b0, 8);
    check_level("even");
    pop_check("even_good");
    pop_check("even_bad");

    // Short low glitch must be rejected.
    clocks_per_bit = 12'd32;
    parity_mode    = 2'd0;
    hold(1'b0, 10);
    hold(1'b1, 64);
    check_level("glitch");
    send_frame(8'hC3, 32, 2'd0, 1'b0, 1'b0, 1'b0, 8);
    pop_check("post_glitch");

    // Break: one all-zero frame with framing error, then nothing while low.
    clocks_per_bit = 12'd32;
    parity_mode    = 2'd0;
    two_stop_bits  = 1'b0;
    hold(1'b0, 20 * 32);
    model_push('{data: 8'h00, pe: 1'b0, fe: 1'b1});
    check_level("break");
    hold(1'b0, 64);
    check_level("break_hold");
    hold(1'b1, 64);
    check_level("break_rel");
    send_frame(8'h3C, 32, 2'd0, 1'b0, 1'b0, 1'b0, 8);
    pop_check("break_entry");
    pop_check("break_next");

    // Fill beyond capacity with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'($urandom), 32, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 6);
      check_level("fill");
    end
    check("full_rts", 32'(rts_pin), 32'h1);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    check("full_ovr", 32'(overrun), 32'h1);
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    model_ovr    = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    for (int i = 0; i < 16; i++) pop_check("drain");
    check_level("drained");

    // Reset mid-frame with entries queued.
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 32, 2'd0, 1'b0, 1'b0, 1'b0, 6);
    check_level("pre_rst");
    clocks_per_bit = 12'd32;
    parity_mode    = 2'd0;
    two_stop_bits  = 1'b0;
    hold(1'b0, 32);
    for (int i = 0; i < 4; i++) hold(1'($urandom_range(0, 1)), 32);
    hold(1'b1, 16);
    reset_n = 1'b0;
    #1;
    check("midrst_count", 32'(fifo_count), 32'h0);
    check("midrst_rts", 32'(rts_pin), 32'h1);
    check("midrst_valid", 32'(rx_valid), 32'h0);
    model_q.delete();
    model_ovr = 1'b0;
    rx_pin    = 1'b1;
    tick(3);
    release_reset();
    tick(4);
    send_frame(8'hA5, 32, 2'd0, 1'b0, 1'b0, 1'b0, 8);
    check_level("post_rst");
    pop_check("post_rst");

    // Random frames, baud rates, formats and consumer activity.
    for (int i = 0; i < 24; i++) begin
      send_frame(8'($urandom), int'($urandom_range(4, 48)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(4, 20)));
      check_level("rand");
      for (int p = int'($urandom_range(0, 2)); p > 0; p--) pop_check("rand_pop");
    end
    while (model_q.size() != 0) pop_check("final_drain");
    pop_check("final_empty");
    check_level("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
